// File: rtl/im_pkg.sv
// Shared types and default widths for the instruction memory and its fetch controller.
package im_pkg;

    localparam int                IM_ADDRESS_WIDTH_DEF  = 6;
    localparam int                INSTRUCTION_WIDTH_DEF = 32;
    localparam logic [31:0]       HALT_INSTR_DEF        = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load has priority over increment; increment wraps modulo 2**AW.
module fetch_pc_reg #(
    parameter int                         AW       = 6,
    parameter logic [AW-1:0]              RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] pc
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/im_fetch_ctrl.sv
// Fetch sequencer: drives im_addr from the PC, captures im_q into a one-entry slot for decode.
//   state   | meaning
//   FS_IDLE | out of reset, waiting for start
//   FS_RUN  | fetching one word per free slot; branches redirect the PC
//   FS_HALT | halt word captured; waiting for start to refetch from RESET_PC
module im_fetch_ctrl
    import im_pkg::*;
#(
    parameter int                              IM_ADDRESS_WIDTH  = IM_ADDRESS_WIDTH_DEF,
    parameter int                              INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEF,
    parameter logic [IM_ADDRESS_WIDTH-1:0]     RESET_PC          = '0,
    parameter logic [INSTRUCTION_WIDTH-1:0]    HALT_INSTR        = HALT_INSTR_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [IM_ADDRESS_WIDTH-1:0]   im_addr,
    input  logic [INSTRUCTION_WIDTH-1:0]  im_q,
    input  logic                          br_valid,
    input  logic [IM_ADDRESS_WIDTH-1:0]   br_target,
    output logic [INSTRUCTION_WIDTH-1:0]  instr,
    output logic [IM_ADDRESS_WIDTH-1:0]   instr_pc,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic                          halted
);

    fetch_state_t                  state_q, state_d;
    logic [INSTRUCTION_WIDTH-1:0]  instr_q, instr_d;
    logic [IM_ADDRESS_WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic                          instr_valid_q, instr_valid_d;
    logic                          halted_q, halted_d;

    logic                          pc_load;
    logic [IM_ADDRESS_WIDTH-1:0]   pc_load_val;
    logic                          pc_inc;
    logic [IM_ADDRESS_WIDTH-1:0]   pc;
    logic                          slot_free;

    fetch_pc_reg #(
        .AW       (IM_ADDRESS_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    assign slot_free = !instr_valid_q || instr_ready;

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        pc_load       = 1'b0;
        pc_load_val   = RESET_PC;
        pc_inc        = 1'b0;

        case (state_q)
            FS_RUN: begin
                // A redirect squashes the slot even when decode is stalling it.
                if (br_valid) begin
                    pc_load       = 1'b1;
                    pc_load_val   = br_target;
                    instr_valid_d = 1'b0;
                end else if (slot_free) begin
                    instr_d       = im_q;
                    instr_pc_d    = pc;
                    instr_valid_d = 1'b1;
                    if (im_q == HALT_INSTR) begin
                        halted_d = 1'b1;
                        state_d  = FS_HALT;
                    end else begin
                        pc_inc = 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d       = FS_RUN;
                    pc_load       = 1'b1;
                    pc_load_val   = RESET_PC;
                    instr_valid_d = 1'b0;
                    halted_d      = 1'b0;
                end else if (instr_valid_q && instr_ready) begin
                    instr_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= FS_IDLE;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign im_addr     = pc;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Bench for im_fetch_ctrl: directed scenarios plus random traffic, all checked against a slot/PC reference model.
module tb_im_fetch_ctrl;
    import im_pkg::*;

    localparam int          AW   = IM_ADDRESS_WIDTH_DEF;
    localparam int          IW   = INSTRUCTION_WIDTH_DEF;
    localparam int          DEP  = 1 << AW;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n, start, br_valid, instr_ready;
    logic [AW-1:0] br_target, im_addr, instr_pc;
    logic [IW-1:0] im_q, instr;
    logic          instr_valid, halted;

    logic [IW-1:0] mem [0:DEP-1];
    assign im_q = mem[im_addr];

    always #5 clk = ~clk;

    im_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .im_addr     (im_addr),
        .im_q        (im_q),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted)
    );

    // Reference model: fetching flag, halted flag, PC and the decode slot.
    bit            m_fetching, m_halted, m_valid;
    int            m_pc, m_ipc;
    logic [IW-1:0] m_instr;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit b, input int t, input bit rdy);
        rst_n       = r;
        start       = s;
        br_valid    = b;
        br_target   = AW'(t);
        instr_ready = rdy;
        if (!r) begin
            m_fetching = 0; m_halted = 0; m_valid = 0;
            m_pc = 0; m_ipc = 0; m_instr = '0;
        end else if (!m_fetching) begin
            if (s) begin
                m_fetching = 1; m_halted = 0; m_valid = 0; m_pc = 0;
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
        end else if (b) begin
            m_pc = t % DEP;
            m_valid = 0;
        end else if (!m_valid || rdy) begin
            m_instr = mem[m_pc];
            m_ipc   = m_pc;
            m_valid = 1;
            if (m_instr == HALT) begin
                m_halted = 1; m_fetching = 0;
            end else begin
                m_pc = (m_pc + 1) % DEP;
            end
        end
        @(posedge clk);
        #1;
        chk("im_addr", 32'(im_addr), 32'(m_pc));
        chk("valid", 32'(instr_valid), 32'(m_valid));
        chk("halted", 32'(halted), 32'(m_halted));
        if (m_valid) begin
            chk("instr", instr, m_instr);
            chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
        end
    endtask

    task automatic restart();
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
    endtask

    task automatic run_until_pc(input int p, input bit rdy);
        int n = 0;
        while (!(instr_valid && int'(instr_pc) == p) && n < 100) begin
            cyc(1, 0, 0, 0, rdy);
            n++;
        end
        chk("reach_pc", 32'(instr_pc), 32'(p));
    endtask

    initial begin
        for (int i = 0; i < DEP; i++) mem[i] = 32'h1000_0000 + i;
        mem[10] = HALT;
        rst_n = 0; start = 0; br_valid = 0; br_target = '0; instr_ready = 1;

        // 1: reset, start, sequential fetch to halt
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", 32'(im_addr), 32'h0);
        cyc(1, 1, 0, 0, 1);
        chk("start_valid0", 32'(instr_valid), 32'h0);
        for (int i = 0; i <= 10; i++) begin
            cyc(1, 0, 0, 0, 1);
            chk("seq_valid", 32'(instr_valid), 32'h1);
            chk("seq_pc", 32'(instr_pc), 32'(i));
            chk("seq_instr", instr, (i == 10) ? HALT : 32'h1000_0000 + i);
        end
        chk("halted", 32'(halted), 32'h1);
        chk("halt_addr", 32'(im_addr), 32'd10);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 1, 33, 1);
        chk("halt_hold_addr", 32'(im_addr), 32'd10);
        chk("halt_valid_clr", 32'(instr_valid), 32'h0);

        // 2 + 5: restart from HALT, then stall
        cyc(1, 1, 0, 0, 1);
        chk("restart_halted", 32'(halted), 32'h0);
        chk("restart_pc", 32'(im_addr), 32'h0);
        run_until_pc(3, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        chk("stall_instr", instr, 32'h1000_0003);
        chk("stall_addr", 32'(im_addr), 32'd4);
        cyc(1, 0, 0, 0, 1);
        chk("unstall_instr", instr, 32'h1000_0004);

        // 3: branch with and without stall
        restart();
        run_until_pc(5, 1);
        cyc(1, 0, 1, 40, 1);
        chk("br_flush", 32'(instr_valid), 32'h0);
        cyc(1, 0, 0, 0, 1);
        chk("br_pc", 32'(instr_pc), 32'd40);
        chk("br_instr", instr, 32'h1000_0028);
        restart();
        run_until_pc(5, 1);
        cyc(1, 0, 1, 40, 0);
        chk("brs_flush", 32'(instr_valid), 32'h0);
        cyc(1, 0, 0, 0, 0);
        chk("brs_pc", 32'(instr_pc), 32'd40);

        // 4: wrap
        mem[10] = 32'h1000_000A;
        restart();
        run_until_pc(5, 1);
        cyc(1, 0, 1, 62, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 1);
            chk("wrap_pc", 32'(instr_pc), 32'((62 + i) % DEP));
        end
        mem[10] = HALT;

        // 5: reset mid-run, start required to resume
        cyc(0, 0, 0, 0, 0);
        chk("midrst_valid", 32'(instr_valid), 32'h0);
        cyc(1, 0, 1, 20, 1);
        cyc(1, 0, 0, 0, 1);
        chk("idle_addr", 32'(im_addr), 32'h0);
        chk("idle_valid", 32'(instr_valid), 32'h0);

        // 6: branch coincident with halt word at im_q
        cyc(1, 1, 0, 0, 1);
        run_until_pc(9, 1);
        cyc(1, 0, 1, 20, 1);
        chk("br_vs_halt", 32'(halted), 32'h0);
        cyc(1, 0, 0, 0, 1);
        chk("br_vs_halt_pc", 32'(instr_pc), 32'd20);

        // random traffic
        for (int i = 0; i < DEP; i++)
            mem[i] = ($urandom_range(0, 19) == 0) ? HALT : $urandom();
        mem[0] = 32'h1234_5678;
        restart();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) != 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) == 0,
                int'($urandom_range(0, DEP - 1)),
                $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
